ecc_serial_host: RTL

- Host-side counterpart of the ECC serial scalar-multiply core's bit-serial interface.
- Takes parallel operands from a controller or bench, then serialises mode, a, b, prime, Px, Py and m, and later nPx and nPy, MSB first onto the core's input pins.
- Deserialises the core's mP and mnP result streams back into parallel words.
- Used as the SoC-side bridge and as the reusable bench driver for the ECC core.

---
 rtl/ecc_serial_host_pkg.sv | 35 +++
 rtl/ecc_serial_deser.sv | 55 +++++
 rtl/ecc_serial_host.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ecc_serial_host_pkg.sv
// Shared definitions for the ECC serial host: operand width codes, Tx FSM states
// and the mode-to-width helper.
package ecc_serial_host_pkg;

  localparam int MAX_BITS = 256;

  typedef enum logic [1:0] {
    BITS32  = 2'd0,
    BITS64  = 2'd1,
    BITS128 = 2'd2,
    BITS256 = 2'd3
  } mode_e;

  typedef enum logic [3:0] {
    IDLE,
    VLD,
    MODE,
    MP,
    WAIT_MP,
    NP_WAIT,
    NPV,
    NP,
    WAIT_MNP
  } tx_state_e;

  function automatic logic [8:0] width_from_mode(input logic [1:0] mode);
    case (mode_e'(mode))
      BITS32:  return 9'd32;
      BITS64:  return 9'd64;
      BITS128: return 9'd128;
      default: return 9'd256;
    endcase
  endfunction

endpackage

// File: rtl/ecc_serial_deser.sv
// MSB-first deserialiser for one result coordinate; a burst shorter than the
// operand width is dropped and flagged with short_err.
module ecc_serial_deser
  import ecc_serial_host_pkg::*;
#(
  parameter int MAX_BITS = ecc_serial_host_pkg::MAX_BITS
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          mode,
  input  logic                valid,
  input  logic                bit_in,
  output logic [MAX_BITS-1:0] word,
  output logic                done,
  output logic                short_err
);

  logic [MAX_BITS-1:0] shift_reg;
  logic [MAX_BITS-1:0] shifted;
  logic [8:0]          count;
  logic [8:0]          n;

  assign n       = width_from_mode(mode);
  assign shifted = {shift_reg[MAX_BITS-2:0], bit_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_reg <= '0;
      count     <= '0;
      word      <= '0;
      done      <= 1'b0;
      short_err <= 1'b0;
    end else begin
      done      <= 1'b0;
      short_err <= 1'b0;
      if (valid) begin
        // Valid staying high after a full word simply begins the next one.
        if (count == n - 9'd1) begin
          word      <= shifted;
          done      <= 1'b1;
          count     <= '0;
          shift_reg <= '0;
        end else begin
          shift_reg <= shifted;
          count     <= count + 9'd1;
        end
      end else if (count != 9'd0) begin
        short_err <= 1'b1;
        count     <= '0;
        shift_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/ecc_serial_host.sv
// Host bridge for the bit-serial ECC core: serialises operands, deserialises results.
// Optional watchdog on the result waits is compiled in with ECC_HOST_TIMEOUT_EN.
module ecc_serial_host
  import ecc_serial_host_pkg::*;
#(
  parameter int          MAX_BITS       = ecc_serial_host_pkg::MAX_BITS,
  parameter int unsigned TIMEOUT_CYCLES = 2000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                ready,
  input  logic [1:0]          mode,
  input  logic [MAX_BITS-1:0] a,
  input  logic [MAX_BITS-1:0] b,
  input  logic [MAX_BITS-1:0] prime,
  input  logic [MAX_BITS-1:0] px,
  input  logic [MAX_BITS-1:0] py,
  input  logic [MAX_BITS-1:0] m,
  input  logic                np_valid,
  output logic                np_ready,
  input  logic [MAX_BITS-1:0] npx,
  input  logic [MAX_BITS-1:0] npy,
  output logic                o_m_P_valid,
  output logic                o_nP_valid,
  output logic                o_mode,
  output logic                o_a,
  output logic                o_b,
  output logic                o_prime,
  output logic                o_Px,
  output logic                o_Py,
  output logic                o_m,
  output logic                o_nPx,
  output logic                o_nPy,
  input  logic                i_mP_valid,
  input  logic                i_mnP_valid,
  input  logic                i_mPx,
  input  logic                i_mPy,
  input  logic                i_mnPx,
  input  logic                i_mnPy,
  output logic [MAX_BITS-1:0] mp_x,
  output logic [MAX_BITS-1:0] mp_y,
  output logic [MAX_BITS-1:0] mnp_x,
  output logic [MAX_BITS-1:0] mnp_y,
  output logic                mp_done,
  output logic                mnp_done,
  output logic                err
);

  tx_state_e     state, state_next;
  logic [8:0]    cnt;
  logic [1:0]    mode_reg;
  logic [8:0]    n;
  logic [8:0]    mp_align;
  logic [8:0]    np_align;
  logic          mp_load;
  logic          np_load;
  logic          timeout;

  assign n        = width_from_mode(mode_reg);
  assign mp_align = 9'(MAX_BITS) - width_from_mode(mode);
  assign np_align = 9'(MAX_BITS) - n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_reg <= '0;
    end else begin
      state <= state_next;
      cnt   <= (state_next != state) ? 9'd0 : cnt + 9'd1;
      if (mp_load) mode_reg <= mode;
    end
  end

  always_comb begin
    state_next = state;
    mp_load    = 1'b0;
    np_load    = 1'b0;
    ready      = 1'b0;
    np_ready   = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) begin
          mp_load    = 1'b1;
          state_next = VLD;
        end
      end
      VLD:      state_next = MODE;
      MODE:     if (cnt == 9'd1) state_next = MP;
      MP:       if (cnt == n - 9'd1) state_next = WAIT_MP;
      // nP is held back until mP is captured so the core never has both pending.
      WAIT_MP: begin
        if (mp_done)      state_next = NP_WAIT;
        else if (timeout) state_next = IDLE;
      end
      NP_WAIT: begin
        np_ready = 1'b1;
        if (np_valid) begin
          np_load    = 1'b1;
          state_next = NPV;
        end
      end
      NPV:      state_next = NP;
      NP:       if (cnt == n - 9'd1) state_next = WAIT_MNP;
      WAIT_MNP: if (mnp_done || timeout) state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

`ifdef ECC_HOST_TIMEOUT_EN
  logic        in_wait;
  logic [31:0] wait_cnt;

  assign in_wait = (state == WAIT_MP) || (state == WAIT_MNP);
  assign timeout = in_wait && (wait_cnt == TIMEOUT_CYCLES - 32'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      wait_cnt <= '0;
    else if (state_next != state) wait_cnt <= '0;
    else if (in_wait)             wait_cnt <= wait_cnt + 32'd1;
  end
`else
  // Watchdog compiled out; the parameter stays so both builds share one interface.
  assign timeout = (TIMEOUT_CYCLES == 32'd0) && 1'b0;
`endif

  // Lines 0..5 carry the mP operands, 6..7 the nP coordinates.
  logic [MAX_BITS-1:0] op_in [8];
  logic [7:0]          line;

  assign op_in[0] = a;
  assign op_in[1] = b;
  assign op_in[2] = prime;
  assign op_in[3] = px;
  assign op_in[4] = py;
  assign op_in[5] = m;
  assign op_in[6] = npx;
  assign op_in[7] = npy;

  for (genvar gi = 0; gi < 8; gi++) begin : g_line
    localparam bit IS_NP = (gi >= 6);
    logic [MAX_BITS-1:0] sh;
    logic                load;
    logic                send;

    assign load = IS_NP ? np_load : mp_load;
    assign send = IS_NP ? (state == NP) : (state == MP);

    // Operands are left-aligned on load so the MSB of the N-bit word leaves first.
    always_ff @(posedge clk or posedge rst) begin
      if (rst)       sh <= '0;
      else if (load) sh <= op_in[gi] << (IS_NP ? np_align : mp_align);
      else if (send) sh <= sh << 1;
    end

    assign line[gi] = send & sh[MAX_BITS-1];
  end

  assign o_a         = line[0];
  assign o_b         = line[1];
  assign o_prime     = line[2];
  assign o_Px        = line[3];
  assign o_Py        = line[4];
  assign o_m         = line[5];
  assign o_nPx       = line[6];
  assign o_nPy       = line[7];
  assign o_m_P_valid = (state == VLD);
  assign o_nP_valid  = (state == NPV);
  assign o_mode      = (state == MODE) && ((cnt == 9'd0) ? mode_reg[1] : mode_reg[0]);

  logic [MAX_BITS-1:0] rx_word [4];
  logic [3:0]          rx_done;
  logic [3:0]          rx_short;
  logic [3:0]          rx_bit;

  assign rx_bit = {i_mnPy, i_mnPx, i_mPy, i_mPx};

  for (genvar gi = 0; gi < 4; gi++) begin : g_rx
    ecc_serial_deser #(.MAX_BITS(MAX_BITS)) u_deser (
      .clk       (clk),
      .rst       (rst),
      .mode      (mode_reg),
      .valid     ((gi < 2) ? i_mP_valid : i_mnP_valid),
      .bit_in    (rx_bit[gi]),
      .word      (rx_word[gi]),
      .done      (rx_done[gi]),
      .short_err (rx_short[gi])
    );
  end

  assign mp_x     = rx_word[0];
  assign mp_y     = rx_word[1];
  assign mnp_x    = rx_word[2];
  assign mnp_y    = rx_word[3];
  assign mp_done  = rx_done[0] & rx_done[1];
  assign mnp_done = rx_done[2] & rx_done[3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          err <= 1'b0;
    else if ((|rx_short) || timeout)  err <= 1'b1;
    else if (mp_load)                 err <= 1'b0;
  end

endmodule
